conv_stream_feeder: RTL and testbench
=====================================

# conv_stream_feeder

Sequencer on the driving side of a streaming convolution engine. On a `go` pulse it:
- reads a raster-ordered input feature map from a 1-cycle-latency BRAM;
- drives the engine's `map_in`/`start` stream;
- captures every `map_out` word qualified by `save` into an output BRAM;
- signals `done` once a full output map is stored.

Inter-layer glue in the conv pipeline, one instance per conv layer.

## Interface

Parameters:
- IN_W, 96, input map width (pixels)
- IN_H, 96, input map height
- KERNEL, 9, kernel edge; output edge = IN_W-KERNEL+1
- NUM_OUT, 7744, output words expected ((IN_W-KERNEL+1)*(IN_H-KERNEL+1))
- FLUSH_MAX, 1024, max zero-fill cycles after last pixel before timeout

Ports:
- clk_in  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- go  in  1  start request, sampled in IDLE only
- busy  out  1  high from go acceptance until done
- done  out  1  one-cycle pulse, output map complete
- err  out  1  sticky error; cleared by reset or accepted go
- rd_addr  out  14  input BRAM address
- rd_data  in  16  signed, valid 1 cycle after rd_addr
- map_in  out  16  signed pixel to engine
- start  out  1  engine enable; high for whole frame
- map_out  in  16  signed engine result
- save  in  1  map_out valid this cycle
- ready  in  1  engine idle/not full (low = engine holds full frame)
- wr_en  out  1  output BRAM write strobe
- wr_addr  out  13  output BRAM address
- wr_data  out  16  output word

## Operation

- States: IDLE, PRIME, STREAM, FLUSH, DONE.
- IDLE:
  - go=1 and ready=1 -> PRIME; clear err; rd_addr=0; wr_count=0.
  - go=1 and ready=0 -> stay IDLE; set err.
- PRIME (1 cycle): rd_addr=1 -> STREAM.
- STREAM:
  - Each cycle: map_in<=rd_data, start<=1, rd_addr increments.
  - Leave when pixel IN_W*IN_H-1 is presented on map_in -> FLUSH.
  - rd_addr saturates at IN_W*IN_H-1.
- FLUSH:
  - map_in<=0, start held 1, flush counter increments.
  - wr_count==NUM_OUT -> DONE.
  - Flush counter == FLUSH_MAX -> DONE with err=1.
- Capture, in any state with start=1:
  - On save=1 and wr_count<NUM_OUT: wr_en=1, wr_data=map_out, wr_addr=wr_count, wr_count++.
  - save=1 when wr_count==NUM_OUT is dropped; sets err.
- DONE (1 cycle): start<=0, map_in<=0, done=1, busy=0 -> IDLE.
- go in any state other than IDLE is ignored.
- Arithmetic: pixels pass through unmodified (16-bit signed, no scaling); counters unsigned.

## Timing

- Reset values: busy=0, done=0, err=0, start=0, map_in=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0; state=IDLE.
- Reset mid-frame returns to IDLE in one edge; start drops the same edge, and no further writes are issued.
- go sampled at edge E0; busy=1 after E0. rd_addr=0 at E0, 1 at E1; start=1 and map_in=pixel0 after E2.
- Pixel k is on map_in after E2+k. The last pixel (9215 at defaults) appears after E2+9215.
- start never glitches low between E2 and DONE; the engine's output alignment depends on continuous start.
- wr_en/wr_addr/wr_data are registered: asserted the edge after save is sampled, so there is 1 cycle of latency.
- save on the same cycle as the NUM_OUT-th capture is handled by counter order: that word is written, then DONE.
- done asserts the cycle after the last write edge; busy falls on the same edge.

## Structure

- Shared package (cnn_pkg): pixel width 16, layer geometry constants (IN_W/IN_H/KERNEL/NUM_OUT per layer), state encoding enum.
- No sub-module needed beyond an optional `fb_addr_counter` (saturating up-counter with clear) used for both rd_addr and wr_count.

## Test plan

- Nominal frame:
  - Stimulus: ramp BRAM (pixel k = k mod 65536); engine model asserts save 88 of every 96 cycles from E2+5.
  - Required: map_in sequence 0..9215; exactly 7744 writes at addresses 0..7743 with data = model output; done 1 cycle; err=0.
- go while ready=0 -> no state change, start stays 0, err=1; a subsequent go with ready=1 clears err and runs normally.
- Engine model never reaches 7744 saves (stops at 7000) -> FLUSH_MAX cycles of map_in=0 after last pixel, then done=1, err=1, start=0.
- Extra save after 7744th write -> no wr_en, err=1, done still fires once.
- rst_n=0 at pixel 4000 -> next edge: start=0, busy=0, all outputs at reset values; a new go restarts from rd_addr=0.
- go held high through a whole frame -> exactly one frame processed; a second frame starts only after returning to IDLE.

Source files
------------

// File: rtl/conv_stream_feeder_pkg.sv
// conv_stream_feeder_pkg: pixel type, bus widths, conv layer geometry and the feeder state encoding.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package conv_stream_feeder_pkg;

   localparam int PIX_W     = 16;
   localparam int RD_ADDR_W = 14;
   localparam int WR_ADDR_W = 13;

   // Geometry of the first conv layer; other layers override the feeder parameters.
   localparam int L1_IN_W      = 96;
   localparam int L1_IN_H      = 96;
   localparam int L1_KERNEL    = 9;
   localparam int L1_NUM_OUT   = (L1_IN_W - L1_KERNEL + 1) * (L1_IN_H - L1_KERNEL + 1);
   localparam int L1_FLUSH_MAX = 1024;

   typedef logic signed [PIX_W-1:0] pix_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_STREAM,
      ST_FLUSH,
      ST_DONE
   } state_t;

endpackage

// File: rtl/conv_stream_feeder_if.sv
// conv_stream_feeder_if: control, input BRAM read, engine stream and output BRAM write signals of one feeder.
// Latency: none; wiring only.
// Backpressure: none here; the engine's ready is only a go-time admission check.
// Modports: master = feeder side (drives rd_addr/map_in/start/wr_*), slave = BRAMs, engine and controller.
interface conv_stream_feeder_if;
   import conv_stream_feeder_pkg::*;

   logic                 go;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [RD_ADDR_W-1:0] rd_addr;
   pix_t                 rd_data;
   pix_t                 map_in;
   logic                 start;
   pix_t                 map_out;
   logic                 save;
   logic                 ready;
   logic                 wr_en;
   logic [WR_ADDR_W-1:0] wr_addr;
   pix_t                 wr_data;

   modport master (
      input  go, rd_data, map_out, save, ready,
      output busy, done, err, rd_addr, map_in, start, wr_en, wr_addr, wr_data
   );

   modport slave (
      output go, rd_data, map_out, save, ready,
      input  busy, done, err, rd_addr, map_in, start, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/conv_stream_feeder_addr_counter.sv
// conv_stream_feeder_addr_counter: saturating up-counter with synchronous clear.
// Latency: count visible one cycle after clr/inc; clr wins over inc.
// Backpressure: none; holds at MAX instead of wrapping.
// Ports: clk_in, rst_n (sync, active-low), clr, inc, cnt[W-1:0].
module conv_stream_feeder_addr_counter #(
   parameter int W   = 14,
   parameter int MAX = 1
) (
   input  logic         clk_in,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != W'(MAX))) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: streams one raster input map from BRAM into the conv engine and stores its outputs.
// Latency: pixel k on map_in 2+k cycles after go; each saved word written 1 cycle after save.
// Backpressure: go refused (err) while engine ready=0; once running the stream never stalls.
// Ports: clk_in, rst_n (sync, active-low), bus (master modport: go/busy/done/err, rd_*, map_*, start, save, ready, wr_*).
module conv_stream_feeder
   import conv_stream_feeder_pkg::*;
#(
   parameter int IN_W      = L1_IN_W,
   parameter int IN_H      = L1_IN_H,
   parameter int KERNEL    = L1_KERNEL,
   parameter int NUM_OUT   = (IN_W - KERNEL + 1) * (IN_H - KERNEL + 1),
   parameter int FLUSH_MAX = L1_FLUSH_MAX
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   conv_stream_feeder_if.master bus
);

   localparam int NPIX = IN_W * IN_H;

   state_t               state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 start_q, start_d;
   pix_t                 map_in_q, map_in_d;
   logic                 wr_en_q, wr_en_d;
   logic [WR_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   pix_t                 wr_data_q, wr_data_d;
   // Pixels presented while streaming, then zero-fill cycles while flushing.
   logic [15:0]          cnt_q, cnt_d;

   logic [RD_ADDR_W-1:0] rd_addr;
   logic [WR_ADDR_W-1:0] wr_count;
   logic                 rd_clr, rd_inc, wr_clr, wr_inc;

   conv_stream_feeder_addr_counter #(.W(RD_ADDR_W), .MAX(NPIX - 1)) u_rd_cnt (
      .clk_in(clk_in), .rst_n(rst_n), .clr(rd_clr), .inc(rd_inc), .cnt(rd_addr)
   );

   conv_stream_feeder_addr_counter #(.W(WR_ADDR_W), .MAX(NUM_OUT)) u_wr_cnt (
      .clk_in(clk_in), .rst_n(rst_n), .clr(wr_clr), .inc(wr_inc), .cnt(wr_count)
   );

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      start_d   = start_q;
      map_in_d  = map_in_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cnt_d     = cnt_q;
      rd_clr    = 1'b0;
      rd_inc    = 1'b0;
      wr_clr    = 1'b0;
      wr_inc    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.go) begin
               if (bus.ready) begin
                  state_d = ST_PRIME;
                  busy_d  = 1'b1;
                  err_d   = 1'b0;
                  rd_clr  = 1'b1;
                  wr_clr  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         // Address 0 is already in the BRAM; issue address 1 so data arrives every cycle from here on.
         ST_PRIME: begin
            rd_inc  = 1'b1;
            cnt_d   = '0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            map_in_d = bus.rd_data;
            start_d  = 1'b1;
            rd_inc   = 1'b1;
            if (cnt_q == 16'(NPIX - 1)) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_FLUSH: begin
            map_in_d = '0;
            // wr_count here is the pre-edge value, so a capture on this edge delays DONE by one cycle.
            if (wr_count == WR_ADDR_W'(NUM_OUT)) begin
               state_d = ST_DONE;
            end else if (cnt_q == 16'(FLUSH_MAX)) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
            if (state_d == ST_DONE) begin
               start_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Capture runs off the registered start so the engine's view of the frame decides what is kept.
      if (start_q && bus.save) begin
         if (wr_count < WR_ADDR_W'(NUM_OUT)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_count;
            wr_data_d = bus.map_out;
            wr_inc    = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         start_q   <= 1'b0;
         map_in_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         start_q   <= start_d;
         map_in_q  <= map_in_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;
   assign bus.start   = start_q;
   assign bus.map_in  = map_in_q;
   assign bus.rd_addr = rd_addr;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb_conv_stream_feeder: directed bench for conv_stream_feeder on an 8x8 map, 3x3 kernel (36 outputs), flush limit 16.
// Models a 1-cycle BRAM and a simple engine whose save pattern is set per scenario.
// Edge indices below count clk_in rising edges after the edge that samples go (E0).
module tb_conv_stream_feeder;

   localparam int TIN_W   = 8;
   localparam int TIN_H   = 8;
   localparam int TKERNEL = 3;
   localparam int TNOUT   = 36;
   localparam int TFLUSH  = 16;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;

   always #5 clk_in = ~clk_in;

   conv_stream_feeder_if bus ();

   conv_stream_feeder #(
      .IN_W(TIN_W), .IN_H(TIN_H), .KERNEL(TKERNEL), .NUM_OUT(TNOUT), .FLUSH_MAX(TFLUSH)
   ) dut (
      .clk_in(clk_in),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [15:0] pix(input int k);
      return 16'(k * 1021 + 32'h8003);
   endfunction

   function automatic logic [15:0] out_val(input int j);
      return 16'(j * 2917 + 32'h4001);
   endfunction

   // Input BRAM: one cycle read latency.
   always @(posedge clk_in) bus.rd_data <= pix(int'(bus.rd_addr));

   // Engine: counts cycles with start high; saves from cycle eng_dly, optionally 6 of every 8 cycles.
   int eng_dly   = 6;
   int eng_limit = TNOUT;
   bit eng_gaps  = 1'b1;
   bit eng_extra = 1'b0;
   int st_cnt, n_saves;
   bit extra_done;

   always @(negedge clk_in) begin
      bus.save    = 1'b0;
      bus.map_out = 16'h5A5A;
      if (bus.start !== 1'b1) begin
         st_cnt     = 0;
         n_saves    = 0;
         extra_done = 1'b0;
      end else begin
         st_cnt = st_cnt + 1;
         if (st_cnt >= eng_dly && (!eng_gaps || ((st_cnt - eng_dly) % 8) < 6)) begin
            if (n_saves < eng_limit) begin
               bus.save    = 1'b1;
               bus.map_out = out_val(n_saves);
               n_saves     = n_saves + 1;
            end else if (eng_extra && !extra_done) begin
               bus.save    = 1'b1;
               bus.map_out = 16'h7777;
               extra_done  = 1'b1;
            end
         end
      end
   end

   // Frame recorder.
   logic [15:0] map_log[$];
   logic [12:0] wa_log[$];
   logic [15:0] wd_log[$];
   int   done_cnt, done_at, gap_cnt, first_wr_at, last_wr_at, first_start_at;
   logic err_at_done, start_at_done, busy_at_done;
   logic [13:0] rd_at1;

   task automatic run_until_done(input int budget, input int tail);
      bit prev_start;
      map_log.delete();
      wa_log.delete();
      wd_log.delete();
      done_cnt = 0; done_at = -1; gap_cnt = 0;
      first_wr_at = -1; last_wr_at = -1; first_start_at = -1;
      err_at_done = 1'bx; start_at_done = 1'bx; busy_at_done = 1'bx;
      rd_at1 = 'x;
      prev_start = bus.start;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk_in);
         #1;
         if (i == 1) rd_at1 = bus.rd_addr;
         if (bus.start === 1'b1) begin
            map_log.push_back(bus.map_in);
            if (first_start_at < 0) first_start_at = i;
         end
         if (bus.wr_en === 1'b1) begin
            wa_log.push_back(bus.wr_addr);
            wd_log.push_back(bus.wr_data);
            if (first_wr_at < 0) first_wr_at = i;
            last_wr_at = i;
         end
         if (prev_start && bus.start !== 1'b1 && bus.done !== 1'b1) gap_cnt++;
         prev_start = (bus.start === 1'b1);
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at       = i;
               err_at_done   = bus.err;
               start_at_done = bus.start;
               busy_at_done  = bus.busy;
            end
         end
         if (done_at >= 0 && i >= done_at + tail) break;
      end
   endtask

   task automatic pulse_go();
      @(negedge clk_in);
      bus.go = 1'b1;
      @(posedge clk_in);
      #1;
      bus.go = 1'b0;
   endtask

   task automatic set_engine(input int dly, input bit gaps, input int limit, input bit extra);
      eng_dly = dly; eng_gaps = gaps; eng_limit = limit; eng_extra = extra;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_in);
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.err, bus.start, bus.wr_en} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.busy, bus.done, bus.err, bus.start, bus.wr_en});
      end
      n_checks++;
      if (bus.map_in !== 16'h0) begin n_fail++; $display("FAIL reset_map_in: got %h want 0000", bus.map_in); end
      n_checks++;
      if (bus.rd_addr !== 14'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
      n_checks++;
      if ({bus.wr_addr, bus.wr_data} !== 29'h0) begin
         n_fail++; $display("FAIL reset_wr_bus: got addr %0d data %h want 0/0", bus.wr_addr, bus.wr_data);
      end
      @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   task automatic test_nominal();
      set_engine(6, 1'b1, TNOUT, 1'b0);
      pulse_go();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.rd_addr !== 14'd0) begin
         n_fail++; $display("FAIL nom_e0: got busy %b rd_addr %0d want 1/0", bus.busy, bus.rd_addr);
      end
      run_until_done(200, 3);
      n_checks++;
      if (rd_at1 !== 14'd1) begin n_fail++; $display("FAIL nom_rd_e1: got %0d want 1", rd_at1); end
      n_checks++;
      if (first_start_at !== 2) begin n_fail++; $display("FAIL nom_start_at: got %0d want 2", first_start_at); end
      n_checks++;
      if (map_log.size() !== 64) begin n_fail++; $display("FAIL nom_map_len: got %0d want 64", map_log.size()); end
      for (int k = 0; k < map_log.size() && k < 64; k++) begin
         n_checks++;
         if (map_log[k] !== pix(k)) begin
            n_fail++; $display("FAIL nom_map_in[%0d]: got %h want %h", k, map_log[k], pix(k));
         end
      end
      n_checks++;
      if (wa_log.size() !== TNOUT) begin n_fail++; $display("FAIL nom_wr_count: got %0d want %0d", wa_log.size(), TNOUT); end
      for (int j = 0; j < wa_log.size(); j++) begin
         n_checks++;
         if (wa_log[j] !== 13'(j) || wd_log[j] !== out_val(j)) begin
            n_fail++; $display("FAIL nom_write[%0d]: got addr %0d data %h want %0d/%h", j, wa_log[j], wd_log[j], j, out_val(j));
         end
      end
      n_checks++;
      if (first_wr_at !== 8 || last_wr_at !== 53) begin
         n_fail++; $display("FAIL nom_wr_timing: got first %0d last %0d want 8/53", first_wr_at, last_wr_at);
      end
      n_checks++;
      if (done_at !== 66 || done_cnt !== 1) begin
         n_fail++; $display("FAIL nom_done: got at %0d count %0d want 66/1", done_at, done_cnt);
      end
      n_checks++;
      if ({err_at_done, busy_at_done, start_at_done} !== 3'b000 || gap_cnt !== 0) begin
         n_fail++; $display("FAIL nom_done_state: got err/busy/start %b%b%b gaps %0d want 000/0",
                            err_at_done, busy_at_done, start_at_done, gap_cnt);
      end
      n_checks++;
      if (bus.rd_addr !== 14'd63) begin n_fail++; $display("FAIL nom_rd_sat: got %0d want 63", bus.rd_addr); end
   endtask

   task automatic test_ready_low();
      set_engine(6, 1'b1, TNOUT, 1'b0);
      bus.ready = 1'b0;
      pulse_go();
      n_checks++;
      if ({bus.busy, bus.err, bus.start} !== 3'b010) begin
         n_fail++; $display("FAIL rdy_refuse: got busy/err/start %b want 010", {bus.busy, bus.err, bus.start});
      end
      repeat (3) @(posedge clk_in);
      #1;
      n_checks++;
      if ({bus.busy, bus.err, bus.start} !== 3'b010) begin
         n_fail++; $display("FAIL rdy_hold: got busy/err/start %b want 010", {bus.busy, bus.err, bus.start});
      end
      bus.ready = 1'b1;
      pulse_go();
      n_checks++;
      if ({bus.busy, bus.err} !== 2'b10) begin
         n_fail++; $display("FAIL rdy_accept: got busy/err %b want 10", {bus.busy, bus.err});
      end
      run_until_done(200, 3);
      n_checks++;
      if (done_at !== 66 || wa_log.size() !== TNOUT || err_at_done !== 1'b0) begin
         n_fail++; $display("FAIL rdy_frame: got done %0d writes %0d err %b want 66/36/0", done_at, wa_log.size(), err_at_done);
      end
   endtask

   task automatic test_timeout();
      set_engine(6, 1'b1, 30, 1'b0);
      pulse_go();
      run_until_done(300, 3);
      n_checks++;
      if (done_at !== 82 || done_cnt !== 1) begin
         n_fail++; $display("FAIL to_done: got at %0d count %0d want 82/1", done_at, done_cnt);
      end
      n_checks++;
      if (map_log.size() !== 80) begin n_fail++; $display("FAIL to_stream_len: got %0d want 80", map_log.size()); end
      for (int k = 64; k < map_log.size(); k++) begin
         n_checks++;
         if (map_log[k] !== 16'h0) begin n_fail++; $display("FAIL to_zero_fill[%0d]: got %h want 0000", k, map_log[k]); end
      end
      n_checks++;
      if ({err_at_done, start_at_done} !== 2'b10 || wa_log.size() !== 30) begin
         n_fail++; $display("FAIL to_state: got err/start %b writes %0d want 10/30", {err_at_done, start_at_done}, wa_log.size());
      end
   endtask

   task automatic test_extra_save();
      set_engine(29, 1'b0, TNOUT, 1'b1);
      pulse_go();
      n_checks++;
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ex_err_clear: got %b want 0", bus.err); end
      run_until_done(200, 3);
      n_checks++;
      if (wa_log.size() !== TNOUT || last_wr_at !== 66) begin
         n_fail++; $display("FAIL ex_writes: got %0d last at %0d want 36/66", wa_log.size(), last_wr_at);
      end
      n_checks++;
      if (done_at !== 67 || done_cnt !== 1 || err_at_done !== 1'b1) begin
         n_fail++; $display("FAIL ex_done: got at %0d count %0d err %b want 67/1/1", done_at, done_cnt, err_at_done);
      end
      n_checks++;
      if (map_log.size() !== 65 || (map_log.size() == 65 && map_log[64] !== 16'h0)) begin
         n_fail++; $display("FAIL ex_flush_word: got len %0d want 65 with last 0000", map_log.size());
      end
   endtask

   task automatic test_mid_reset();
      set_engine(6, 1'b1, TNOUT, 1'b0);
      pulse_go();
      repeat (30) @(posedge clk_in);
      #1;
      n_checks++;
      if (bus.map_in !== pix(28)) begin n_fail++; $display("FAIL mr_pixel28: got %h want %h", bus.map_in, pix(28)); end
      @(negedge clk_in);
      rst_n = 1'b0;
      @(posedge clk_in);
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.err, bus.start, bus.wr_en} !== 5'b0 || bus.map_in !== 16'h0) begin
         n_fail++; $display("FAIL mr_flags: got %b map_in %h want 00000/0000",
                            {bus.busy, bus.done, bus.err, bus.start, bus.wr_en}, bus.map_in);
      end
      n_checks++;
      if (bus.rd_addr !== 14'd0 || bus.wr_addr !== 13'd0 || bus.wr_data !== 16'h0) begin
         n_fail++; $display("FAIL mr_buses: got rd %0d wa %0d wd %h want 0/0/0", bus.rd_addr, bus.wr_addr, bus.wr_data);
      end
      @(posedge clk_in);
      #1;
      n_checks++;
      if (bus.wr_en !== 1'b0 || bus.start !== 1'b0) begin
         n_fail++; $display("FAIL mr_quiet: got wr_en %b start %b want 0/0", bus.wr_en, bus.start);
      end
      @(negedge clk_in);
      rst_n = 1'b1;
      pulse_go();
      run_until_done(200, 3);
      n_checks++;
      if (rd_at1 !== 14'd1 || done_at !== 66 || wa_log.size() !== TNOUT) begin
         n_fail++; $display("FAIL mr_restart: got rd_e1 %0d done %0d writes %0d want 1/66/36", rd_at1, done_at, wa_log.size());
      end
      n_checks++;
      if (wa_log.size() == 0 || wa_log[0] !== 13'd0) begin
         n_fail++; $display("FAIL mr_first_addr: got %0d entries want first addr 0", wa_log.size());
      end
   endtask

   task automatic test_go_held();
      set_engine(6, 1'b1, TNOUT, 1'b0);
      @(negedge clk_in);
      bus.go = 1'b1;
      @(posedge clk_in);
      #1;
      run_until_done(200, 0);
      n_checks++;
      if (done_at !== 66 || map_log.size() !== 64) begin
         n_fail++; $display("FAIL gh_frame1: got done %0d stream len %0d want 66/64", done_at, map_log.size());
      end
      @(posedge clk_in);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin
         n_fail++; $display("FAIL gh_idle_gap: got busy %b start %b want 0/0", bus.busy, bus.start);
      end
      @(posedge clk_in);
      #1;
      bus.go = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.rd_addr !== 14'd0) begin
         n_fail++; $display("FAIL gh_restart: got busy %b rd_addr %0d want 1/0", bus.busy, bus.rd_addr);
      end
      run_until_done(200, 3);
      n_checks++;
      if (done_at !== 66 || done_cnt !== 1 || wa_log.size() !== TNOUT) begin
         n_fail++; $display("FAIL gh_frame2: got done %0d count %0d writes %0d want 66/1/36", done_at, done_cnt, wa_log.size());
      end
   endtask

   initial begin
      bus.go    = 1'b0;
      bus.ready = 1'b1;
      test_reset();
      test_nominal();
      test_ready_low();
      test_timeout();
      test_extra_save();
      test_mid_reset();
      test_go_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
